// File: rtl/map_irq_dcnt.sv
// Down-counting cycle IRQ unit for FCG / LZ93D50-class mappers, with save-state port.
// Optional prescaler on register 5 / save-state index 7 when IRQ_PRESC_EN is defined.
module map_irq_dcnt #(
  parameter int CTR_W      = 16,
  parameter int LATCH_MODE = 1,
  parameter bit RST_ON     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       reg_we,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_di,
  input  logic       ss_we,
  input  logic [2:0] ss_addr,
  input  logic [7:0] ss_di,
  output logic [7:0] ss_do,
  output logic       irq
);

  logic [CTR_W-1:0] ctr, latch;
  logic             pend, irq_on, auto_rl;
  logic [23:0]      ctr_x, lat_x;
  logic [1:0]       rb, ss_lb;
  logic             wr_ctrl, wr_byte, wr_ack, wr_presc, drop, qtick, dec;

`ifdef IRQ_PRESC_EN
  logic [7:0] presc, pcnt;
`endif

  function automatic logic [23:0] set_byte(input logic [23:0] v, input logic [1:0] i,
                                           input logic [7:0] d);
    logic [23:0] r;
    r = v;
    case (i)
      2'd0:    r[7:0]   = d;
      2'd1:    r[15:8]  = d;
      default: r[23:16] = d;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [23:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      default: return v[23:16];
    endcase
  endfunction

  // A byte lane exists only if it holds at least one counter bit.
  function automatic logic byte_ok(input logic [1:0] i);
    return (int'(i) * 8) < CTR_W;
  endfunction

  assign ctr_x = 24'(ctr);
  assign lat_x = 24'(latch);
  assign rb    = 2'(reg_addr - 3'd1);
  assign ss_lb = 2'(ss_addr - 3'd3);

  assign wr_ctrl = reg_we && !ss_we && reg_addr == 3'd0;
  assign wr_byte = reg_we && !ss_we && reg_addr >= 3'd1 && reg_addr <= 3'd3 && byte_ok(rb);
  assign wr_ack  = reg_we && !ss_we && reg_addr == 3'd4;
`ifdef IRQ_PRESC_EN
  assign wr_presc = reg_we && !ss_we && reg_addr == 3'd5;
`else
  assign wr_presc = 1'b0;
`endif

  // Writes that touch the counter (or its prescale phase) swallow a coincident tick.
  assign drop  = wr_ctrl || wr_presc || (wr_byte && LATCH_MODE == 0);
  assign qtick = tick && !ss_we && irq_on && !drop;
`ifdef IRQ_PRESC_EN
  assign dec   = qtick && (pcnt == presc);
`else
  assign dec   = qtick;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr     <= '0;
      latch   <= '0;
      pend    <= 1'b0;
      irq_on  <= RST_ON;
      auto_rl <= 1'b0;
`ifdef IRQ_PRESC_EN
      presc   <= '0;
      pcnt    <= '0;
`endif
    end else if (ss_we) begin
      case (ss_addr)
        3'd0, 3'd1, 3'd2: ctr   <= CTR_W'(set_byte(ctr_x, ss_addr[1:0], ss_di));
        3'd3, 3'd4, 3'd5: latch <= CTR_W'(set_byte(lat_x, ss_lb, ss_di));
        3'd6: {auto_rl, pend, irq_on} <= ss_di[2:0];
        default: begin
`ifdef IRQ_PRESC_EN
          presc <= ss_di;
          pcnt  <= '0;
`endif
        end
      endcase
    end else begin
      if (wr_ctrl) begin
        irq_on  <= reg_di[0];
        auto_rl <= reg_di[1];
        pend    <= 1'b0;
        if (LATCH_MODE != 0) ctr <= latch;
`ifdef IRQ_PRESC_EN
        pcnt    <= '0;
`endif
      end
      if (wr_byte) begin
        if (LATCH_MODE != 0) latch <= CTR_W'(set_byte(lat_x, rb, reg_di));
        else                 ctr   <= CTR_W'(set_byte(ctr_x, rb, reg_di));
      end
      if (wr_ack) pend <= 1'b0;
`ifdef IRQ_PRESC_EN
      if (wr_presc) begin
        presc <= reg_di;
        pcnt  <= '0;
      end
      if (qtick) pcnt <= (pcnt == presc) ? 8'd0 : pcnt + 8'd1;
`endif
      // Placed after the ack so a zero tick in the same cycle leaves pend set.
      if (dec) begin
        if (ctr == '0) begin
          ctr  <= auto_rl ? latch : '1;
          pend <= 1'b1;
        end else begin
          ctr  <= ctr - 1'b1;
        end
      end
    end
  end

  assign irq = pend;

  always_comb begin
    ss_do = 8'h00;
    case (ss_addr)
      3'd0, 3'd1, 3'd2: ss_do = get_byte(ctr_x, ss_addr[1:0]);
      3'd3, 3'd4, 3'd5: ss_do = get_byte(lat_x, ss_lb);
      3'd6:             ss_do = {5'b0, auto_rl, pend, irq_on};
      default: begin
`ifdef IRQ_PRESC_EN
        ss_do = presc;
`else
        ss_do = 8'hFF;
`endif
      end
    endcase
  end

endmodule
